// File: rtl/riscv_estage_mc.sv
// Execute stage: forwarding muxes, single-cycle ALU and branch compare, plus an
// iterative radix-2 multiplier / restoring divider that stalls upstream while busy.
`timescale 1ns/1ps
module riscv_estage_mc #(
  parameter int WIDTH = 64
) (
  input  logic             i_riscv_estage_clk,
  input  logic             i_riscv_estage_rst,
  input  logic             i_riscv_estage_valid,
  input  logic             i_riscv_estage_flush,
  input  logic [WIDTH-1:0] i_riscv_estage_rs1data,
  input  logic [WIDTH-1:0] i_riscv_estage_rs2data,
  input  logic [WIDTH-1:0] i_riscv_estage_rdata_wb,
  input  logic [WIDTH-1:0] i_riscv_estage_rddata_m,
  input  logic [WIDTH-1:0] i_riscv_estage_imm_m,
  input  logic [1:0]       i_riscv_estage_fwda,
  input  logic [1:0]       i_riscv_estage_fwdb,
  input  logic             i_riscv_estage_oprnd1sel,
  input  logic             i_riscv_estage_oprnd2sel,
  input  logic [WIDTH-1:0] i_riscv_estage_pc,
  input  logic [WIDTH-1:0] i_riscv_estage_simm,
  input  logic [1:0]       i_riscv_estage_funcsel,
  input  logic [3:0]       i_riscv_estage_aluctrl,
  input  logic [1:0]       i_riscv_estage_mulctrl,
  input  logic [1:0]       i_riscv_estage_divctrl,
  input  logic [3:0]       i_riscv_estage_bcond,
  output logic [WIDTH-1:0] o_riscv_estage_result,
  output logic             o_riscv_estage_branchtaken,
  output logic             o_riscv_estage_valid,
  output logic             o_riscv_estage_stall
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = (WIDTH == 64) ? 6 : 5;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic             neg_q, neg_d, isdiv_q, isdiv_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             br_q, br_d, valid_q, valid_d;

  logic [WIDTH-1:0] fwd_a, fwd_b, alu_a, alu_b, alu_res;
  logic [SW-1:0]    shamt;
  logic             br_cmp;

  always_comb begin
    case (i_riscv_estage_fwda)
      2'd0:    fwd_a = i_riscv_estage_rs1data;
      2'd1:    fwd_a = i_riscv_estage_rdata_wb;
      2'd2:    fwd_a = i_riscv_estage_rddata_m;
      default: fwd_a = i_riscv_estage_imm_m;
    endcase
    case (i_riscv_estage_fwdb)
      2'd0:    fwd_b = i_riscv_estage_rs2data;
      2'd1:    fwd_b = i_riscv_estage_rdata_wb;
      2'd2:    fwd_b = i_riscv_estage_rddata_m;
      default: fwd_b = i_riscv_estage_imm_m;
    endcase
  end

  assign alu_a = i_riscv_estage_oprnd1sel ? fwd_a : i_riscv_estage_pc;
  assign alu_b = i_riscv_estage_oprnd2sel ? i_riscv_estage_simm : fwd_b;
  assign shamt = alu_b[SW-1:0];

  always_comb begin
    case (i_riscv_estage_aluctrl)
      4'd0:    alu_res = alu_a + alu_b;
      4'd1:    alu_res = alu_a - alu_b;
      4'd2:    alu_res = alu_a << shamt;
      4'd3:    alu_res = {{(WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      4'd4:    alu_res = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
      4'd5:    alu_res = alu_a ^ alu_b;
      4'd6:    alu_res = alu_a >> shamt;
      4'd7:    alu_res = $unsigned($signed(alu_a) >>> shamt);
      4'd8:    alu_res = alu_a | alu_b;
      4'd9:    alu_res = alu_a & alu_b;
      4'd10:   alu_res = alu_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    case (i_riscv_estage_bcond[2:0])
      3'b000:  br_cmp = (fwd_a == fwd_b);
      3'b001:  br_cmp = (fwd_a != fwd_b);
      3'b100:  br_cmp = ($signed(fwd_a) < $signed(fwd_b));
      3'b101:  br_cmp = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110:  br_cmp = (fwd_a < fwd_b);
      3'b111:  br_cmp = (fwd_a >= fwd_b);
      default: br_cmp = 1'b0;
    endcase
  end

  // Operand conditioning: the iterative core works on magnitudes only
  logic             is_mul, is_div, div_signed, sgn_a, sgn_b;
  logic             div_zero, div_ovf, div_special;
  logic [WIDTH-1:0] mag_a, mag_b, special_res;

  assign is_mul      = (i_riscv_estage_funcsel == 2'd1);
  assign is_div      = (i_riscv_estage_funcsel == 2'd2);
  assign div_signed  = ~i_riscv_estage_divctrl[0];
  assign sgn_a       = fwd_a[WIDTH-1] & (is_div ? div_signed : (i_riscv_estage_mulctrl != 2'd3));
  assign sgn_b       = fwd_b[WIDTH-1] & (is_div ? div_signed : ~i_riscv_estage_mulctrl[1]);
  assign mag_a       = sgn_a ? -fwd_a : fwd_a;
  assign mag_b       = sgn_b ? -fwd_b : fwd_b;
  assign div_zero    = (fwd_b == '0);
  assign div_ovf     = div_signed & (fwd_a == MOST_NEG) & (fwd_b == '1);
  assign div_special = is_div & (div_zero | div_ovf);

  always_comb begin
    if (div_zero) special_res = i_riscv_estage_divctrl[1] ? fwd_a : '1;
    else          special_res = i_riscv_estage_divctrl[1] ? '0 : fwd_a;
  end

  // One iteration step; hi holds partial product / remainder, lo holds multiplier / quotient
  logic [WIDTH:0]     mul_sum, div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   step_hi, step_lo, div_raw, fin_res;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : {WIDTH{1'b0}})};
  assign div_sh  = {hi_q, lo_q[WIDTH-1]};
  assign div_ge  = (div_sh >= {1'b0, opb_q});

  always_comb begin
    if (isdiv_q) begin
      step_hi = div_ge ? (div_sh[WIDTH-1:0] - opb_q) : div_sh[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign prod     = {step_hi, step_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign div_raw  = ctrl_q[1] ? step_hi : step_lo;

  always_comb begin
    if (isdiv_q)             fin_res = neg_q ? -div_raw : div_raw;
    else if (ctrl_q == 2'd0) fin_res = prod_fix[WIDTH-1:0];
    else                     fin_res = prod_fix[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    isdiv_d  = isdiv_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    br_d     = br_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_riscv_estage_valid && !i_riscv_estage_flush) begin
          if ((is_mul || is_div) && !div_special) begin
            hi_d    = '0;
            lo_d    = is_div ? mag_a : mag_b;
            opb_d   = is_div ? mag_b : mag_a;
            isdiv_d = is_div;
            ctrl_d  = is_div ? i_riscv_estage_divctrl : i_riscv_estage_mulctrl;
            // Remainder takes the dividend's sign; product and quotient take the xor
            neg_d   = (is_div && i_riscv_estage_divctrl[1]) ? sgn_a : (sgn_a ^ sgn_b);
            cnt_d   = CW'(WIDTH);
            state_d = BUSY;
          end else if (div_special) begin
            result_d = special_res;
            br_d     = 1'b0;
            valid_d  = 1'b1;
          end else begin
            result_d = alu_res;
            br_d     = i_riscv_estage_bcond[3] & br_cmp;
            valid_d  = 1'b1;
          end
        end
      end
      default: begin
        if (i_riscv_estage_flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_d = fin_res;
            br_d     = 1'b0;
            valid_d  = 1'b1;
            state_d  = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_riscv_estage_clk or negedge i_riscv_estage_rst) begin
    if (!i_riscv_estage_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      isdiv_q  <= 1'b0;
      ctrl_q   <= 2'd0;
      result_q <= '0;
      br_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      isdiv_q  <= isdiv_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      br_q     <= br_d;
      valid_q  <= valid_d;
    end
  end

  assign o_riscv_estage_result      = result_q;
  assign o_riscv_estage_branchtaken = br_q;
  assign o_riscv_estage_valid       = valid_q;
  assign o_riscv_estage_stall       = (state_q == BUSY);

endmodule

// File: tb/tb_riscv_estage_mc.sv
// Scoreboard bench for riscv_estage_mc: a driver pushes expected results from an
// arithmetic reference model; a negedge monitor pops and compares on o_valid.
`timescale 1ns/1ps
module tb_riscv_estage_mc;
  localparam int W = 64;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         valid_i, flush_i, o1_i, o2_i;
  logic [W-1:0] rs1_i, rs2_i, wb_i, mm_i, imm_i, pc_i, simm_i;
  logic [1:0]   fa_i, fb_i, fs_i, mc_i, dc_i;
  logic [3:0]   alu_i, bc_i;
  logic [W-1:0] result_o;
  logic         br_o, valid_o, stall_o;

  riscv_estage_mc #(.WIDTH(W)) dut (
    .i_riscv_estage_clk(clk), .i_riscv_estage_rst(rst_n),
    .i_riscv_estage_valid(valid_i), .i_riscv_estage_flush(flush_i),
    .i_riscv_estage_rs1data(rs1_i), .i_riscv_estage_rs2data(rs2_i),
    .i_riscv_estage_rdata_wb(wb_i), .i_riscv_estage_rddata_m(mm_i),
    .i_riscv_estage_imm_m(imm_i), .i_riscv_estage_fwda(fa_i), .i_riscv_estage_fwdb(fb_i),
    .i_riscv_estage_oprnd1sel(o1_i), .i_riscv_estage_oprnd2sel(o2_i),
    .i_riscv_estage_pc(pc_i), .i_riscv_estage_simm(simm_i),
    .i_riscv_estage_funcsel(fs_i), .i_riscv_estage_aluctrl(alu_i),
    .i_riscv_estage_mulctrl(mc_i), .i_riscv_estage_divctrl(dc_i),
    .i_riscv_estage_bcond(bc_i), .o_riscv_estage_result(result_o),
    .o_riscv_estage_branchtaken(br_o), .o_riscv_estage_valid(valid_o),
    .o_riscv_estage_stall(stall_o)
  );

  typedef struct {
    logic [W-1:0] rs1, rs2, wb, mm, imm, pc, simm;
    logic [1:0]   fa, fb, fs, mc, dc;
    logic         o1, o2;
    logic [3:0]   alu, bc;
  } ins_t;

  typedef struct {
    logic [W-1:0] res;
    logic         br;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] held_res;
  logic         held_br;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] rs, input ins_t t);
    logic [W-1:0] src[4];
    src[0] = rs; src[1] = t.wb; src[2] = t.mm; src[3] = t.imm;
    return src[sel];
  endfunction

  function automatic void model(input ins_t t, output logic [W-1:0] res, output logic br, output bit multi);
    logic [W-1:0] fa, fb, a, b;
    logic signed [2*W-1:0] pa, pb, pr;
    int unsigned sh;
    bit sgn, sa, sb;
    fa = pick(t.fa, t.rs1, t);
    fb = pick(t.fb, t.rs2, t);
    res = '0; br = 1'b0; multi = 1'b0;
    if (t.fs == 2'd1) begin
      sa = (t.mc != 2'd3);
      sb = (t.mc <= 2'd1);
      pa = sa ? {{W{fa[W-1]}}, fa} : {{W{1'b0}}, fa};
      pb = sb ? {{W{fb[W-1]}}, fb} : {{W{1'b0}}, fb};
      pr = pa * pb;
      res = (t.mc == 2'd0) ? pr[W-1:0] : pr[2*W-1:W];
      multi = 1'b1;
    end else if (t.fs == 2'd2) begin
      sgn = (t.dc == 2'd0) || (t.dc == 2'd2);
      if (fb == '0) begin
        res = (t.dc >= 2'd2) ? fa : '1;
      end else if (sgn && fa == MOST_NEG && fb == '1) begin
        res = (t.dc >= 2'd2) ? '0 : fa;
      end else begin
        multi = 1'b1;
        if (sgn) res = (t.dc >= 2'd2) ? $signed(fa) % $signed(fb) : $signed(fa) / $signed(fb);
        else     res = (t.dc >= 2'd2) ? fa % fb : fa / fb;
      end
    end else begin
      a = t.o1 ? fa : t.pc;
      b = t.o2 ? t.simm : fb;
      sh = (W == 64) ? int'(b[5:0]) : int'(b[4:0]);
      case (t.alu)
        4'd0: res = a + b;
        4'd1: res = a - b;
        4'd2: res = a << sh;
        4'd3: res = ($signed(a) < $signed(b)) ? 1 : 0;
        4'd4: res = (a < b) ? 1 : 0;
        4'd5: res = a ^ b;
        4'd6: res = a >> sh;
        4'd7: res = $signed(a) >>> sh;
        4'd8: res = a | b;
        4'd9: res = a & b;
        4'd10: res = b;
        default: res = '0;
      endcase
      case (t.bc[2:0])
        3'd0: br = (fa == fb);
        3'd1: br = (fa != fb);
        3'd4: br = ($signed(fa) < $signed(fb));
        3'd5: br = ($signed(fa) >= $signed(fb));
        3'd6: br = (fa < fb);
        3'd7: br = (fa >= fb);
        default: br = 1'b0;
      endcase
      br = br & t.bc[3];
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [W-1:0] rv();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = '1;
      2: v = MOST_NEG;
      3: v = 1;
      4: v = W'($urandom_range(0, 100));
      5: v = -W'($urandom_range(1, 100));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  function automatic ins_t blank();
    ins_t t;
    t.rs1 = '0; t.rs2 = '0; t.wb = '0; t.mm = '0; t.imm = '0; t.pc = '0; t.simm = '0;
    t.fa = 0; t.fb = 0; t.fs = 0; t.mc = 0; t.dc = 0; t.o1 = 1; t.o2 = 0; t.alu = 0; t.bc = 0;
    return t;
  endfunction

  function automatic ins_t rand_ins();
    ins_t t;
    int k;
    t.rs1 = rv(); t.rs2 = rv(); t.wb = rv(); t.mm = rv(); t.imm = rv(); t.pc = rv(); t.simm = rv();
    t.fa = 2'($urandom); t.fb = 2'($urandom); t.o1 = 1'($urandom); t.o2 = 1'($urandom);
    t.alu = 4'($urandom); t.mc = 2'($urandom); t.dc = 2'($urandom); t.bc = 4'($urandom);
    k = $urandom_range(0, 9);
    t.fs = (k <= 3) ? 2'd0 : (k <= 6) ? 2'd3 : (k == 7) ? 2'd1 : 2'd2;
    return t;
  endfunction

  task automatic apply(input ins_t t);
    rs1_i = t.rs1; rs2_i = t.rs2; wb_i = t.wb; mm_i = t.mm; imm_i = t.imm;
    pc_i = t.pc; simm_i = t.simm; fa_i = t.fa; fb_i = t.fb; o1_i = t.o1; o2_i = t.o2;
    fs_i = t.fs; alu_i = t.alu; mc_i = t.mc; dc_i = t.dc; bc_i = t.bc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one instruction; for iterative ops also checks stall and throws
  // junk valid requests at the busy unit, which must be ignored.
  task automatic issue(input ins_t t);
    exp_t e;
    logic [W-1:0] r;
    logic b;
    bit m;
    int t0;
    model(t, r, b, m);
    apply(t);
    valid_i = 1'b1; flush_i = 1'b0;
    t0 = cyc;
    e.res = r; e.br = b; e.cyc = m ? t0 + W + 1 : t0 + 1;
    sb_q.push_back(e);
    tick();
    valid_i = 1'b0;
    if (m) begin
      for (int k = 1; k <= W; k++) begin
        chk("stall_busy", W'(stall_o), W'(1));
        apply(rand_ins());
        valid_i = 1'($urandom);
        tick();
      end
      valid_i = 1'b0;
      chk("stall_done", W'(stall_o), W'(0));
    end
  endtask

  task automatic issue_flushed(input ins_t t);
    apply(t);
    valid_i = 1'b1; flush_i = 1'b1;
    tick();
    valid_i = 1'b0; flush_i = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_res = '0;
      held_br = 1'b0;
    end else if (valid_o) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got result %h at cycle %0d, expected no output", result_o, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("result", result_o, e.res);
        chk("branchtaken", W'(br_o), W'(e.br));
        chk("latency", W'(cyc), W'(e.cyc));
        $display("txn cycle %0d: result=%h branch=%0d", cyc, result_o, br_o);
        held_res = e.res;
        held_br = e.br;
      end
    end else begin
      chk("hold_result", result_o, held_res);
      chk("hold_branch", W'(br_o), W'(held_br));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    ins_t t;
    int t0;
    apply(blank());
    valid_i = 1'b0; flush_i = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    chk("reset_result", result_o, '0);
    chk("reset_valid", W'(valid_o), W'(0));
    chk("reset_stall", W'(stall_o), W'(0));
    chk("reset_branch", W'(br_o), W'(0));
    rst_n = 1'b1;
    tick();

    // ADD through mem forward with negative immediate
    t = blank(); t.fa = 2; t.mm = 5; t.o1 = 1; t.o2 = 1; t.simm = -W'(7); t.alu = 0;
    issue(t);
    // BLT -1 < 1 via wb forward
    t = blank(); t.fa = 0; t.rs1 = '1; t.fb = 1; t.wb = 1; t.bc = 4'b1100;
    issue(t);
    // Shift boundaries: shift by 63 and by 64 (wraps to 0)
    t = blank(); t.rs1 = MOST_NEG; t.o2 = 1; t.simm = 63; t.alu = 7;
    issue(t);
    t.simm = 64; t.alu = 6;
    issue(t);
    // MULHU all ones
    t = blank(); t.fs = 1; t.mc = 3; t.rs1 = '1; t.rs2 = '1;
    issue(t);
    // MULH most-negative squared
    t = blank(); t.fs = 1; t.mc = 1; t.rs1 = MOST_NEG; t.rs2 = MOST_NEG;
    issue(t);
    // DIV / REM -7 / 2, DIVU by zero, signed overflow
    t = blank(); t.fs = 2; t.dc = 0; t.rs1 = -W'(7); t.rs2 = 2;
    issue(t);
    t.dc = 2;
    issue(t);
    t.dc = 1; t.rs2 = '0;
    issue(t);
    t.dc = 3;
    issue(t);
    t = blank(); t.fs = 2; t.dc = 0; t.rs1 = MOST_NEG; t.rs2 = '1;
    issue(t);
    t.dc = 2;
    issue(t);

    // Flush an in-flight DIV 100/7 at T+10, new ADD at T+12
    t = blank(); t.fs = 2; t.dc = 0; t.rs1 = 100; t.rs2 = 7;
    apply(t); valid_i = 1'b1; t0 = cyc;
    tick();
    valid_i = 1'b0;
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick();
    chk("flush_cycle", W'(cyc), W'(t0 + 12));
    chk("stall_after_flush", W'(stall_o), W'(0));
    t = blank(); t.rs1 = 40; t.fb = 0; t.rs2 = 2; t.alu = 0;
    issue(t);

    // Flush with valid in IDLE must not accept
    issue_flushed(t);

    // Reset in the middle of a MUL
    t = blank(); t.fs = 1; t.mc = 0; t.rs1 = 12345; t.rs2 = 678;
    apply(t); valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("midreset_result", result_o, '0);
    chk("midreset_valid", W'(valid_o), W'(0));
    chk("midreset_stall", W'(stall_o), W'(0));
    chk("midreset_branch", W'(br_o), W'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (W + 5) tick();

    // Randomised mix, back-to-back where the op allows it
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 19) == 0) issue_flushed(rand_ins());
      else                            issue(rand_ins());
    end

    repeat (5) tick();
    chk("scoreboard_empty", W'(sb_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_estage_mc.md
RISCV_ESTAGE_MC -- requirements
Module: riscv_estage_mc

Interface
REQ-001 Parameter WIDTH, default 64, datapath width; SHALL be 32 or 64.
REQ-002 i_riscv_estage_clk  in  1  sole clock; all state on its rising edge.
REQ-003 i_riscv_estage_rst  in  1  asynchronous, active-low reset.
REQ-004 i_riscv_estage_valid  in  1  instruction present this cycle.
REQ-005 i_riscv_estage_flush  in  1  kill in-flight/incoming instruction.
REQ-006 i_riscv_estage_rs1data, i_riscv_estage_rs2data  in  WIDTH each  register-file operands.
REQ-007 i_riscv_estage_rdata_wb, i_riscv_estage_rddata_m, i_riscv_estage_imm_m  in  WIDTH each  forwarding sources.
REQ-008 i_riscv_estage_fwda, i_riscv_estage_fwdb  in  2 each  forward select: 0 rs, 1 wb, 2 mem, 3 imm_m.
REQ-009 i_riscv_estage_oprnd1sel  in  1  ALU A: 0 pc, 1 forwarded rs1.
REQ-010 i_riscv_estage_oprnd2sel  in  1  ALU B: 0 forwarded rs2, 1 simm.
REQ-011 i_riscv_estage_pc, i_riscv_estage_simm  in  WIDTH each  PC and sign-extended immediate.
REQ-012 i_riscv_estage_funcsel  in  2  0 ALU, 1 MUL, 2 DIV, 3 treated as ALU.
REQ-013 i_riscv_estage_aluctrl  in  4  0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASSB; others give 0.
REQ-014 i_riscv_estage_mulctrl  in  2  0 MUL,1 MULH,2 MULHSU,3 MULHU.
REQ-015 i_riscv_estage_divctrl  in  2  0 DIV,1 DIVU,2 REM,3 REMU.
REQ-016 i_riscv_estage_bcond  in  4  bit3 branch enable; bits2:0 funct3 (BEQ,BNE,-,-,BLT,BGE,BLTU,BGEU).
REQ-017 o_riscv_estage_result  out  WIDTH  registered result.
REQ-018 o_riscv_estage_branchtaken  out  1  registered, qualified by o_riscv_estage_valid.
REQ-019 o_riscv_estage_valid  out  1  one-cycle pulse, result/branch valid.
REQ-020 o_riscv_estage_stall  out  1  high while a MUL/DIV is iterating; upstream SHALL hold.

Function
REQ-021 Forward muxes SHALL feed: ALU operand muxes, MUL/DIV operands (fwd A/B directly), branch comparator (fwd A/B directly).
REQ-022 FSM states IDLE, BUSY; accept = valid & ~flush & state IDLE.
REQ-023 ALU accept at cycle T: result, branchtaken registered, o_valid=1 at T+1; state stays IDLE; back-to-back accepts every cycle allowed.
REQ-024 Shift amount = B[5:0] when WIDTH=64, B[4:0] when WIDTH=32; SLT/SLTU result zero-extended 0/1.
REQ-025 branchtaken = bcond[3] & compare(fwdA,fwdB); 0 for MUL/DIV; funct3 010/011 give 0.
REQ-026 MUL/DIV accept at T: operand magnitudes and sign flags captured, counter loaded WIDTH, IDLE->BUSY; stall=1 from T+1.
REQ-027 BUSY: one radix-2 step per cycle (shift-add multiply of 2*WIDTH product; restoring divide); counter decrements; at counter reaching 0, sign fix-up applied, result registered, o_valid=1 at T+WIDTH+1, BUSY->IDLE, stall=0 in that cycle.
REQ-028 MUL returns product low WIDTH bits; MULH/MULHSU/MULHU high WIDTH bits with signed x signed / signed x unsigned / unsigned x unsigned.
REQ-029 Divide by zero: quotient all ones, remainder = dividend; signed overflow (most-negative / -1): quotient = dividend, remainder 0; both complete as ALU latency (o_valid at T+1), no BUSY.
REQ-030 Signed division rounds toward zero; remainder sign = dividend sign.
REQ-031 i_valid during BUSY SHALL be ignored.
REQ-032 flush in BUSY: return to IDLE next edge, no o_valid, stall drops next cycle; flush with valid in IDLE: no accept.
REQ-033 o_result and o_branchtaken SHALL hold last value when o_valid=0.

Reset
REQ-034 Reset low: state IDLE, counter 0, o_result 0, o_branchtaken 0, o_valid 0, o_stall 0, immediately and independent of clock.
REQ-035 Reset asserted mid-BUSY SHALL abort operation with no o_valid after release.

Verification
REQ-036 WIDTH=64, ALU ADD, fwda=2 rddata_m=5, oprnd2sel=1 simm=-7 -> o_valid at T+1, result 0xFFFF_FFFF_FFFF_FFFE.
REQ-037 BLT, fwda=0 rs1=-1, fwdb=1 rdata_wb=1, bcond=4'b1100 -> branchtaken=1 with o_valid at T+1.
REQ-038 WIDTH=64 MULHU rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> stall cycles T+1..T+64, o_valid at T+65, result 0xFFFF_FFFF_FFFF_FFFE.
REQ-039 WIDTH=32 DIV -7/2 -> result -3 at T+33; REM -7/2 -> -1; DIVU x/0 -> 0xFFFF_FFFF at T+1.
REQ-040 DIV 100/7 accepted, flush at T+10 -> no o_valid, stall 0 at T+12, new ADD accepted T+12 gives o_valid T+13.
REQ-041 Reset low at T+5 of a MUL -> outputs 0 immediately, no o_valid after release.
